muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle unsigned 16-bit multiply/divide unit in the execute stage, directly downstream of the 3-read-port register file.
- Consumes the two read operands the register file presents after each falling clock edge and returns a 16-bit result for write-back through the register file write port.
- Uses a start/done handshake so the pipeline control stalls while the unit is busy.

Parameters:
WIDTH, 16, operand and result width in bits; the iteration count equals WIDTH.
CNT_W, 4, iteration counter width; must equal clog2(WIDTH).

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
Reset  input  1  one clock; reset is asynchronous and active-low.
Start  input  1  request; sampled on a rising edge only in IDLE or DONE.
Op  input  2  00 MULLO, 01 MULHI, 10 DIV (quotient), 11 REM (remainder); captured with Start.
Operand_A  input  WIDTH  multiplicand or dividend; captured with Start.
Operand_B  input  WIDTH  multiplier or divisor; captured with Start.
Busy  output  1  high while in RUN.
Done  output  1  high for exactly one cycle (state DONE) when Result is new.
Result  output  WIDTH  result selected by the captured Op; holds its value until the next completion.
Div_By_Zero  output  1  high with Done when Op is DIV or REM and the captured Operand_B is 0; held until the next accepted Start.

Behaviour:
- Reset low, asynchronous: state IDLE, counter 0, Busy 0, Done 0, Result 0x0000, Div_By_Zero 0, internal accumulators 0. Reset low mid-operation aborts the operation immediately; no Done is produced.
- States: IDLE, RUN, DONE.
- IDLE: when Start=1 at an edge, capture Op, Operand_A and Operand_B, clear the counter and Div_By_Zero, then go to RUN.
  - Exception: if Op is DIV or REM and Operand_B = 0, go directly to DONE.
    - Result = 0xFFFF for DIV, Operand_A for REM.
    - Div_By_Zero = 1.
- RUN, one iteration per edge, WIDTH edges total:
  - MUL: shift-add into a 2*WIDTH-bit product register.
  - DIV/REM: restoring division using a WIDTH+1-bit partial remainder.
  - Counter increments each edge. At the edge where counter = WIDTH-1, load Result from the final value and go to DONE:
    - MULLO: product[WIDTH-1:0]
    - MULHI: product[2*WIDTH-1:WIDTH]
    - DIV: quotient
    - REM: remainder
- Latency: Start accepted at edge N → Busy is high between edges N and N+16 → Done is high between edges N+16 and N+17.
- DONE: Done=1 for exactly one cycle.
  - Start=1 at the next edge is accepted: back-to-back operation, same capture rules as IDLE, go to RUN.
  - Otherwise go to IDLE.
- Start while in RUN is ignored. Op and operand changes during RUN have no effect.
- Operand_A and Operand_B are only sampled at the accepting edge. The register file updates its outputs on the falling edge, so they are stable at the rising edge.
- Arithmetic is unsigned only:
  - No overflow flag.
  - MULHI/MULLO together form the full 32-bit product.
  - Quotient and remainder satisfy A = Q*B + R with R < B.
- Result is never cleared except by Reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - Op encodings MULLO/MULHI/DIV/REM
  - State encoding IDLE/RUN/DONE
  - Constant DIV0_QUOTIENT = 16'hFFFF
- Optional single sub-module muldiv_datapath holds the shift-add/restoring iteration step (combinational next-state of the accumulators). The FSM and counter stay in muldiv_unit.

Test Plan:
- Reset low mid-RUN (after 5 iterations of any op) → Busy, Done, Result, Div_By_Zero all 0 immediately; after Reset releases, the unit sits in IDLE with no Done.
- MULLO with A=300, B=200 → Done is high exactly 16 cycles after acceptance, Result=0xEA60, Div_By_Zero=0; rerun as MULHI → Result=0x0000.
- MULHI with A=0xFFFF, B=0xFFFF → Result=0xFFFE; MULLO with the same operands → Result=0x0001.
- DIV with A=1000, B=7 → Result=142 (0x008E); REM with the same operands → Result=6; Busy is high for exactly 16 cycles each.
- DIV with A=5, B=0 → Done on the cycle after acceptance, Result=0xFFFF, Div_By_Zero=1; REM with A=5, B=0 → Result=0x0005, Div_By_Zero=1.
- Start pulsed with different operands during RUN → ignored, and the original result is produced. Start held high in the DONE cycle → new op accepted back-to-back; the second Done arrives 17 cycles after the first.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle unsigned multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIV   = 2'b10,
        OP_REM   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake and operand/result bus between pipeline control and the unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/muldiv_datapath.sv
// One iteration of shift-add multiply and restoring divide, purely combinational.
module muldiv_datapath #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH:0]     rem_i,
    input  logic [WIDTH-1:0]   quo_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH:0]     rem_o,
    output logic [WIDTH-1:0]   quo_o
);
    localparam int unsigned RW = WIDTH + 1;

    logic [WIDTH:0]   psum;
    logic [WIDTH+1:0] shifted;

    always_comb begin
        // Low half of prod starts as the multiplier and is consumed LSB-first.
        psum   = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + (prod_i[0] ? {1'b0, mcand_i} : '0);
        prod_o = {psum, prod_i[WIDTH-1:1]};

        // quo starts as the dividend; its MSB shifts into the partial remainder.
        shifted = {rem_i, quo_i[WIDTH-1]};
        if (shifted >= {2'b00, divisor_i}) begin
            rem_o = RW'(shifted - {2'b00, divisor_i});
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit: FSM, iteration counter and result registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    muldiv_if.slave  bus
);
    state_e             state_q;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     rem_d;
    logic [WIDTH-1:0]   quo_d;

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .mcand_i   (a_q),
        .divisor_i (b_q),
        .prod_i    (prod_q),
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .prod_o    (prod_d),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULLO;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.operand_a;
                        b_q    <= bus.operand_b;
                        cnt_q  <= '0;
                        dbz_q  <= 1'b0;
                        prod_q <= {{WIDTH{1'b0}}, bus.operand_b};
                        rem_q  <= '0;
                        quo_q  <= bus.operand_a;
                        if (is_div_op(bus.op) && (bus.operand_b == '0)) begin
                            // Divide by zero skips RUN and completes on the next cycle.
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            dbz_q    <= 1'b1;
                            result_q <= (bus.op == OP_DIV) ? DIV0_QUOTIENT : bus.operand_a;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    prod_q <= prod_d;
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        case (op_q)
                            OP_MULLO: result_q <= prod_d[WIDTH-1:0];
                            OP_MULHI: result_q <= prod_d[2*WIDTH-1:WIDTH];
                            OP_DIV:   result_q <= quo_d;
                            default:  result_q <= rem_d[WIDTH-1:0];
                        endcase
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: cycle-level reference model plus directed and random operations.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic chk_en = 1'b0;

    muldiv_if #(.WIDTH(16)) bus ();

    muldiv_unit #(
        .WIDTH (16),
        .CNT_W (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input op_e op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        case (op)
            OP_MULLO: return p[15:0];
            OP_MULHI: return p[31:16];
            OP_DIV:   return (b == 0) ? 16'hFFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Reference model: an accepted op yields its arithmetic result 16 edges later.
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [15:0] m_res = '0, m_pend = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_res = '0; m_left = 0;
        end else if (m_busy) begin
            m_done = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                if ((bus.op == OP_DIV || bus.op == OP_REM) && bus.operand_b == 0) begin
                    m_done = 1'b1;
                    m_dbz  = 1'b1;
                    m_res  = ref_result(bus.op, bus.operand_a, bus.operand_b);
                end else begin
                    m_busy = 1'b1;
                    m_dbz  = 1'b0;
                    m_left = 16;
                    m_pend = ref_result(bus.op, bus.operand_a, bus.operand_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy",   {31'b0, bus.busy},        {31'b0, m_busy});
            chk("model_done",   {31'b0, bus.done},        {31'b0, m_done});
            chk("model_result", {16'b0, bus.result},      {16'b0, m_res});
            chk("model_dbz",    {31'b0, bus.div_by_zero}, {31'b0, m_dbz});
        end
    end

    // Caller is at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input op_e op, input logic [15:0] a, input logic [15:0] b);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.operand_a = ~a;
        bus.operand_b = b ^ 16'h5A5A;
    endtask

    task automatic wait_done(output int lat, output int busy_n, output int done_cyc);
        lat    = 0;
        busy_n = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        done_cyc = cyc;
    endtask

    task automatic run_lit(input string name, input op_e op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic exp_dbz, input int exp_lat);
        int lat, busy_n, dc;
        start_op(op, a, b);
        wait_done(lat, busy_n, dc);
        chk({name, "_result"}, {16'b0, bus.result}, {16'b0, exp_res});
        chk({name, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, exp_dbz});
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, busy_n, exp_lat);
    endtask

    initial begin
        int lat, busy_n, dc1, dc2, gap;
        logic [1:0] r_op;
        logic [15:0] r_a, r_b;

        bus.start = 1'b0; bus.op = OP_MULLO; bus.operand_a = '0; bus.operand_b = '0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_result", {16'b0, bus.result}, 32'h0);
        chk("reset_busy",   {31'b0, bus.busy},   32'h0);
        #20 rst_n = 1'b1;
        @(negedge clk);

        run_lit("mullo_300x200",  OP_MULLO, 16'd300,  16'd200,  16'hEA60, 1'b0, 16);
        run_lit("mulhi_300x200",  OP_MULHI, 16'd300,  16'd200,  16'h0000, 1'b0, 16);
        run_lit("mulhi_ffff",     OP_MULHI, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 16);
        run_lit("mullo_ffff",     OP_MULLO, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 16);
        run_lit("div_1000_7",     OP_DIV,   16'd1000, 16'd7,    16'd142,  1'b0, 16);
        run_lit("rem_1000_7",     OP_REM,   16'd1000, 16'd7,    16'd6,    1'b0, 16);
        run_lit("div_5_0",        OP_DIV,   16'd5,    16'd0,    16'hFFFF, 1'b1, 0);
        run_lit("rem_5_0",        OP_REM,   16'd5,    16'd0,    16'h0005, 1'b1, 0);
        run_lit("div_after_dbz",  OP_DIV,   16'd9,    16'd3,    16'd3,    1'b0, 16);

        // Start pulses with other operands while RUN must be ignored.
        repeat (2) @(negedge clk);
        start_op(OP_MULLO, 16'd300, 16'd200);
        repeat (3) @(negedge clk);
        start_op(OP_DIV, 16'd9, 16'd3);
        wait_done(lat, busy_n, dc1);
        chk("ignore_start_result", {16'b0, bus.result}, 32'h0000EA60);

        // Back-to-back: second op is issued in the DONE cycle of the first.
        start_op(OP_DIV, 16'd1000, 16'd7);
        wait_done(lat, busy_n, dc1);
        start_op(OP_REM, 16'd1000, 16'd7);
        wait_done(lat, busy_n, dc2);
        gap = dc2 - dc1;
        chk("b2b_done_gap", gap, 17);
        chk("b2b_result", {16'b0, bus.result}, 32'd6);

        // Asynchronous reset after 5 iterations aborts the operation.
        @(negedge clk);
        start_op(OP_MULHI, 16'hFFFF, 16'h1234);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",   {31'b0, bus.busy},        32'h0);
        chk("abort_done",   {31'b0, bus.done},        32'h0);
        chk("abort_result", {16'b0, bus.result},      32'h0);
        chk("abort_dbz",    {31'b0, bus.div_by_zero}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_abort_done", {31'b0, bus.done}, 32'h0);
            chk("post_abort_busy", {31'b0, bus.busy}, 32'h0);
        end

        // Random operations with random idle gaps, including divide by zero.
        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = 16'($urandom);
            r_b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) r_b = 16'($urandom_range(1, 15));
            start_op(op_e'(r_op), r_a, r_b);
            wait_done(lat, busy_n, dc1);
            chk("rand_result", {16'b0, bus.result}, {16'b0, ref_result(op_e'(r_op), r_a, r_b)});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
